// File: rtl/radio_audio_averager.sv
// Decimating block-sum stage feeding the radio audio input: sums N signed samples,
// queues each completed sum in a small FIFO and presents the head on a stb/ack stream.
module radio_audio_averager #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int DEFAULT_AVG  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                           sample_valid,
  input  logic [31:0]                    average_samples,
  input  logic                           average_samples_stb,
  output logic                           average_samples_ack,
  output logic [31:0]                    audio_out,
  output logic                           audio_out_stb,
  input  logic                           audio_out_ack,
  output logic [15:0]                    overflow_count
);

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DEF_N = 16'(DEFAULT_AVG);

  logic          ack_q, ack_d;
  logic          pend_v_q, pend_v_d;
  logic [15:0]   pend_n_q, pend_n_d;
  logic [15:0]   n_q, n_d;
  logic [31:0]   acc_q, acc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]   out_q, out_d;
  logic          out_stb_q, out_stb_d;
  logic [15:0]   ovf_q, ovf_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic          cfg_accept;
  logic [15:0]   cfg_n;
  logic          apply_pend;
  logic [15:0]   n_eff;
  logic [31:0]   sum_next;
  logic          blk_done;
  logic          fifo_empty, fifo_full;
  logic          pop, push, drop;
  logic [15:0]   unused_avg_hi;

  assign unused_avg_hi = average_samples[31:16];

  always_comb begin
    cfg_accept = average_samples_stb && !ack_q;
    cfg_n      = (average_samples[15:0] == 16'd0) ? 16'd1 : average_samples[15:0];
    // A pending N accepted on an earlier edge takes effect whenever no block is open,
    // so it governs the sample (if any) arriving on this edge.
    apply_pend = (cnt_q == 16'd0) && pend_v_q;
    n_eff      = apply_pend ? pend_n_q : n_q;
    sum_next   = acc_q + 32'(sample_in);
    blk_done   = sample_valid && (cnt_q == n_eff - 16'd1);

    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !out_stb_q && !fifo_empty;
    push       = blk_done && (!fifo_full || pop);
    drop       = blk_done && fifo_full && !pop;
  end

  always_comb begin
    ack_d     = cfg_accept;
    pend_v_d  = pend_v_q;
    pend_n_d  = pend_n_q;
    n_d       = n_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    out_d     = out_q;
    out_stb_d = out_stb_q;
    ovf_d     = ovf_q;

    if (apply_pend) begin
      n_d      = pend_n_q;
      pend_v_d = 1'b0;
    end
    if (cfg_accept) begin
      pend_n_d = cfg_n;
      pend_v_d = 1'b1;
    end

    if (sample_valid) begin
      if (blk_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_next;
        cnt_d = cnt_q + 16'd1;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (drop && (ovf_q != '1)) ovf_d = ovf_q + 16'd1;

    if (out_stb_q && audio_out_ack) begin
      out_stb_d = 1'b0;
    end else if (pop) begin
      out_d     = mem_q[rd_ptr_q[AW-1:0]];
      out_stb_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q     <= 1'b0;
      pend_v_q  <= 1'b0;
      pend_n_q  <= '0;
      n_q       <= DEF_N;
      acc_q     <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      out_q     <= '0;
      out_stb_q <= 1'b0;
      ovf_q     <= '0;
    end else begin
      ack_q     <= ack_d;
      pend_v_q  <= pend_v_d;
      pend_n_q  <= pend_n_d;
      n_q       <= n_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      out_q     <= out_d;
      out_stb_q <= out_stb_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: emptiness is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= sum_next;
  end

  assign average_samples_ack = ack_q;
  assign audio_out           = out_q;
  assign audio_out_stb       = out_stb_q;
  assign overflow_count      = ovf_q;

endmodule

// File: tb/tb_radio_audio_averager.sv
// Scoreboard bench for radio_audio_averager: directed scenarios plus random traffic
// compared against a block-list / buffer-occupancy reference model.
module tb_radio_audio_averager;

  localparam int SW  = 16;
  localparam int FD  = 4;
  localparam int DEF = 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [SW-1:0] sample_in = '0;
  logic                 sample_valid = 1'b0;
  logic [31:0]          average_samples = '0;
  logic                 average_samples_stb = 1'b0;
  logic                 average_samples_ack;
  logic [31:0]          audio_out;
  logic                 audio_out_stb;
  logic                 audio_out_ack = 1'b0;
  logic [15:0]          overflow_count;

  radio_audio_averager #(.SAMPLE_WIDTH(SW), .FIFO_DEPTH(FD), .DEFAULT_AVG(DEF)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sample_in           (sample_in),
    .sample_valid        (sample_valid),
    .average_samples     (average_samples),
    .average_samples_stb (average_samples_stb),
    .average_samples_ack (average_samples_ack),
    .audio_out           (audio_out),
    .audio_out_stb       (audio_out_stb),
    .audio_out_ack       (audio_out_ack),
    .overflow_count      (overflow_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // Reference model: open block as a list of samples, FIFO contents, output-slot occupancy.
  int m_n;
  int m_pend;
  bit m_pend_v;
  bit m_ack;
  bit m_busy;
  int m_ovf;
  int blk[$];
  int mfifo[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_n = DEF; m_pend = 0; m_pend_v = 0; m_ack = 0; m_busy = 0; m_ovf = 0;
    blk.delete(); mfifo.delete(); exp_q.delete();
  endtask

  task automatic model_edge();
    bit pop, xfer, blocked;
    int sum;
    pop     = !m_busy && (mfifo.size() > 0);
    xfer    = m_busy && audio_out_ack;
    blocked = (mfifo.size() == FD) && !pop;
    if (blk.size() == 0 && m_pend_v) begin
      m_n = m_pend;
      m_pend_v = 0;
    end
    if (average_samples_stb && !m_ack) begin
      m_pend = (average_samples[15:0] == 16'd0) ? 1 : int'(average_samples[15:0]);
      m_pend_v = 1;
      m_ack = 1;
    end else begin
      m_ack = 0;
    end
    if (pop) void'(mfifo.pop_front());
    if (sample_valid) begin
      blk.push_back(int'(sample_in));
      if (blk.size() == m_n) begin
        sum = 0;
        foreach (blk[i]) sum += blk[i];
        blk.delete();
        if (blocked) begin
          if (m_ovf < 65535) m_ovf++;
        end else begin
          mfifo.push_back(sum);
          exp_q.push_back(sum);
        end
      end
    end
    if (xfer) m_busy = 0;
    else if (pop) m_busy = 1;
  endtask

  task automatic step(input bit v, input int s, input bit cs, input logic [31:0] cv, input bit a);
    sample_valid        = v;
    sample_in           = SW'(s);
    average_samples_stb = cs;
    average_samples     = cv;
    audio_out_ack       = a;
    model_edge();
    @(posedge clk);
    #1;
    chk("cfg_ack", 32'(average_samples_ack), 32'(m_ack));
    chk("out_stb", 32'(audio_out_stb), 32'(m_busy));
    chk("overflow", 32'(overflow_count), 32'(m_ovf));
  endtask

  task automatic cfg(input logic [31:0] val, input bit a);
    step(0, 0, 1, val, a);
    step(0, 0, 0, '0, a);
  endtask

  task automatic idle(input int n, input bit a);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, a);
  endtask

  always @(negedge clk) begin
    if (rst && audio_out_stb && audio_out_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%0h required=none", audio_out);
      end else begin
        chk("audio_out", audio_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    #2;
    chk("rst_stb", 32'(audio_out_stb), 0);
    chk("rst_out", audio_out, 0);
    chk("rst_ack", 32'(average_samples_ack), 0);
    chk("rst_ovf", 32'(overflow_count), 0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // default N=1, ack tied high
    step(1, 5, 0, '0, 1);
    step(1, -3, 0, '0, 1);
    step(1, 7, 0, '0, 1);
    idle(6, 1);

    // N=4 with irregular gaps
    cfg(4, 1);
    step(1, 100, 0, '0, 1);
    idle(2, 1);
    step(1, 200, 0, '0, 1);
    step(1, -50, 0, '0, 1);
    idle(3, 1);
    step(1, 10, 0, '0, 1);
    idle(4, 1);

    // mid-block reconfiguration
    step(1, 1, 0, '0, 1);
    step(1, 1, 0, '0, 1);
    cfg(2, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 0, '0, 1);
    idle(6, 1);

    // backpressure and overflow
    cfg(1, 0);
    for (int i = 1; i <= 7; i++) step(1, i, 0, '0, 0);
    idle(3, 0);
    chk("held_out", audio_out, 1);
    chk("ovf_two", 32'(overflow_count), 2);
    idle(16, 1);

    // extremes
    cfg(0, 1);
    step(1, -32768, 0, '0, 1);
    idle(4, 1);
    cfg(65535, 1);
    for (int i = 0; i < 65535; i++) step(1, 32767, 0, '0, 1);
    idle(4, 1);

    // asynchronous reset with data held and a block open
    cfg(1, 0);
    step(1, 9, 0, '0, 0);
    step(0, 0, 1, 3, 0);
    step(1, 1, 0, '0, 0);
    step(1, 1, 1, 3, 0);
    #1 rst = 1'b0;
    #1;
    chk("arst_stb", 32'(audio_out_stb), 0);
    chk("arst_out", audio_out, 0);
    chk("arst_ack", 32'(average_samples_ack), 0);
    chk("arst_ovf", 32'(overflow_count), 0);
    model_reset();
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 2, 0, '0, 1);
    idle(6, 1);
    cfg(3, 1);
    for (int i = 0; i < 3; i++) step(1, 2, 0, '0, 1);
    idle(6, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit v, cs, a;
      logic [31:0] cv;
      v  = ($urandom_range(0, 2) != 0);
      cs = ($urandom_range(0, 30) == 0);
      cv = {$urandom_range(0, 65535), 16'(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5))};
      a  = ((i / 200) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      step(v, int'($urandom_range(0, 65535)), cs, cv, a);
    end
    idle(30, 1);
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
